// File: rtl/rs_alu_pkg.sv
// Shared ALU parameters: opcode width and encodings, datapath width, default ROB tag width.
// Also holds the operand record used by the reservation station.
package rs_alu_pkg;
  localparam int OPCODE_W  = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_LUI   = 4'd10,
    OP_AUIPC = 4'd11
  } opcode_e;

  // busy=1: value still pending on its producer tag
  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
  } opnd_t;
endpackage

// File: rtl/rs_alu_if.sv
// Issue, result-broadcast and dispatch bundle between decoder/CDB and the ALU reservation station.
interface rs_alu_if import rs_alu_pkg::*; #(parameter int TAG_W = TAG_W_DEF);
  logic                rollback;
  logic                in_valid;
  logic [OPCODE_W-1:0] in_op;
  logic [DATA_W-1:0]   in_pc;
  logic [DATA_W-1:0]   in_imm;
  logic [TAG_W-1:0]    in_tag;
  logic                in_q1_busy;
  logic                in_q2_busy;
  logic [TAG_W-1:0]    in_q1;
  logic [TAG_W-1:0]    in_q2;
  logic [DATA_W-1:0]   in_v1;
  logic [DATA_W-1:0]   in_v2;
  logic                cdb0_valid;
  logic                cdb1_valid;
  logic [TAG_W-1:0]    cdb0_tag;
  logic [TAG_W-1:0]    cdb1_tag;
  logic [DATA_W-1:0]   cdb0_data;
  logic [DATA_W-1:0]   cdb1_data;
  logic                full;
  logic [OPCODE_W-1:0] op_to_alu;
  logic [DATA_W-1:0]   v1_to_alu;
  logic [DATA_W-1:0]   v2_to_alu;
  logic [DATA_W-1:0]   imm_to_alu;
  logic [DATA_W-1:0]   pc_to_alu;
  logic [TAG_W-1:0]    tag_to_alu;
  logic                is_empty_to_alu;

  modport master (
    output rollback, in_valid, in_op, in_pc, in_imm, in_tag,
           in_q1_busy, in_q2_busy, in_q1, in_q2, in_v1, in_v2,
           cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_data, cdb1_data,
    input  full, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu,
           tag_to_alu, is_empty_to_alu
  );

  modport slave (
    input  rollback, in_valid, in_op, in_pc, in_imm, in_tag,
           in_q1_busy, in_q2_busy, in_q1, in_q2, in_v1, in_v2,
           cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_data, cdb1_data,
    output full, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu,
           tag_to_alu, is_empty_to_alu
  );
endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-index set-bit selector with a found flag.
module rs_priority_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // scan downward so the lowest set bit is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = i[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds issued ops until both operands arrive via the CDBs,
// then dispatches the lowest-index ready entry to the ALU through registered outputs.
module rs_alu import rs_alu_pkg::*; #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  rs_alu_if.slave   bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  q1_busy;
  logic [RS_SIZE-1:0]  q2_busy;
  logic [OPCODE_W-1:0] op   [RS_SIZE];
  logic [DATA_W-1:0]   pc   [RS_SIZE];
  logic [DATA_W-1:0]   imm  [RS_SIZE];
  logic [TAG_W-1:0]    tag  [RS_SIZE];
  logic [TAG_W-1:0]    q1   [RS_SIZE];
  logic [TAG_W-1:0]    q2   [RS_SIZE];
  logic [DATA_W-1:0]   v1   [RS_SIZE];
  logic [DATA_W-1:0]   v2   [RS_SIZE];

  opnd_t               nxt1 [RS_SIZE];
  opnd_t               nxt2 [RS_SIZE];
  opnd_t               in1;
  opnd_t               in2;

  logic [RS_SIZE-1:0]  ready;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    rdy_idx;
  logic                free_found;
  logic                rdy_found;
  logic                do_issue;

  logic [OPCODE_W-1:0] op_p1;
  logic [DATA_W-1:0]   v1_p1;
  logic [DATA_W-1:0]   v2_p1;
  logic [DATA_W-1:0]   imm_p1;
  logic [DATA_W-1:0]   pc_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic                empty_p1;

  // cdb0 has priority when both broadcasts carry the awaited tag
  function automatic opnd_t resolve(input opnd_t cur, input logic [TAG_W-1:0] q);
    opnd_t r;
    r = cur;
    if (cur.busy) begin
      if (bus.cdb0_valid && bus.cdb0_tag == q) begin
        r.busy = 1'b0;
        r.val  = bus.cdb0_data;
      end else if (bus.cdb1_valid && bus.cdb1_tag == q) begin
        r.busy = 1'b0;
        r.val  = bus.cdb1_data;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      nxt1[i] = resolve('{busy: q1_busy[i], val: v1[i]}, q1[i]);
      nxt2[i] = resolve('{busy: q2_busy[i], val: v2[i]}, q2[i]);
    end
    in1 = resolve('{busy: bus.in_q1_busy, val: bus.in_v1}, bus.in_q1);
    in2 = resolve('{busy: bus.in_q2_busy, val: bus.in_v2}, bus.in_q2);
  end

  assign ready    = busy & ~q1_busy & ~q2_busy;
  assign do_issue = bus.in_valid && free_found && !bus.rollback;

  rs_priority_enc #(.N(RS_SIZE)) u_free_sel (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_priority_enc #(.N(RS_SIZE)) u_ready_sel (
    .req   (ready),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  // ---- stage p1: entry control and dispatch registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      q1_busy  <= '0;
      q2_busy  <= '0;
      op_p1    <= '0;
      v1_p1    <= '0;
      v2_p1    <= '0;
      imm_p1   <= '0;
      pc_p1    <= '0;
      tag_p1   <= '0;
      empty_p1 <= 1'b1;
    end else begin
      empty_p1 <= 1'b1;
      if (bus.rollback) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            q1_busy[i] <= nxt1[i].busy;
            q2_busy[i] <= nxt2[i].busy;
          end
        end
        if (rdy_found) begin
          busy[rdy_idx] <= 1'b0;
          op_p1         <= op[rdy_idx];
          v1_p1         <= v1[rdy_idx];
          v2_p1         <= v2[rdy_idx];
          imm_p1        <= imm[rdy_idx];
          pc_p1         <= pc[rdy_idx];
          tag_p1        <= tag[rdy_idx];
          empty_p1      <= 1'b0;
        end
        if (do_issue) begin
          busy[free_idx]    <= 1'b1;
          q1_busy[free_idx] <= in1.busy;
          q2_busy[free_idx] <= in2.busy;
        end
      end
    end
  end

  // Entry payload carries no reset; busy alone qualifies it.
  always_ff @(posedge clk) begin
    if (!bus.rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          v1[i] <= nxt1[i].val;
          v2[i] <= nxt2[i].val;
        end
      end
    end
    if (do_issue) begin
      op[free_idx]  <= bus.in_op;
      pc[free_idx]  <= bus.in_pc;
      imm[free_idx] <= bus.in_imm;
      tag[free_idx] <= bus.in_tag;
      q1[free_idx]  <= bus.in_q1;
      q2[free_idx]  <= bus.in_q2;
      v1[free_idx]  <= in1.val;
      v2[free_idx]  <= in2.val;
    end
  end

  assign bus.full            = &busy;
  assign bus.op_to_alu       = op_p1;
  assign bus.v1_to_alu       = v1_p1;
  assign bus.v2_to_alu       = v2_p1;
  assign bus.imm_to_alu      = imm_p1;
  assign bus.pc_to_alu       = pc_p1;
  assign bus.tag_to_alu      = tag_p1;
  assign bus.is_empty_to_alu = empty_p1;
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: issue/dispatch latency, CDB wakeup and bypass, full handling,
// rollback and asynchronous reset, each against hand-computed values.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rs_alu_if #(.TAG_W(4)) bus ();

  rs_alu #(.RS_SIZE(8), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.rollback   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_pc      = '0;
    bus.in_imm     = '0;
    bus.in_tag     = '0;
    bus.in_q1_busy = 1'b0;
    bus.in_q2_busy = 1'b0;
    bus.in_q1      = '0;
    bus.in_q2      = '0;
    bus.in_v1      = '0;
    bus.in_v2      = '0;
    bus.cdb0_valid = 1'b0;
    bus.cdb1_valid = 1'b0;
    bus.cdb0_tag   = '0;
    bus.cdb1_tag   = '0;
    bus.cdb0_data  = '0;
    bus.cdb1_data  = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] tg,
                       input logic q1b, input logic [3:0] q1, input logic [31:0] v1,
                       input logic q2b, input logic [3:0] q2, input logic [31:0] v2);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_tag     = tg;
    bus.in_pc      = 32'h1000 + {28'd0, tg};
    bus.in_imm     = 32'h20 + {28'd0, tg};
    bus.in_q1_busy = q1b;
    bus.in_q1      = q1;
    bus.in_v1      = v1;
    bus.in_q2_busy = q2b;
    bus.in_q2      = q2;
    bus.in_v2      = v2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_in();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.is_empty_to_alu, 1);
    check("rst_op", bus.op_to_alu, 0);
    check("rst_v1", bus.v1_to_alu, 0);
    check("rst_tag", bus.tag_to_alu, 0);
    step();
    step();
    @(negedge clk) rst = 1'b0;

    // ready ADD: written at first edge, on outputs after the second
    issue(OP_ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    step();
    clear_in();
    check("add_not_yet", bus.is_empty_to_alu, 1);
    step();
    check("add_empty", bus.is_empty_to_alu, 0);
    check("add_op", bus.op_to_alu, OP_ADD);
    check("add_v1", bus.v1_to_alu, 5);
    check("add_v2", bus.v2_to_alu, 7);
    check("add_tag", bus.tag_to_alu, 3);
    check("add_pc", bus.pc_to_alu, 32'h1003);
    check("add_imm", bus.imm_to_alu, 32'h23);
    step();
    check("add_one_cycle", bus.is_empty_to_alu, 1);
    check("add_hold_op", bus.op_to_alu, OP_ADD);

    // SUB waits on tag 2, woken by cdb0 one cycle later
    issue(OP_SUB, 4'd1, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd3);
    step();
    clear_in();
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd2;
    bus.cdb0_data  = 32'h10;
    step();
    clear_in();
    check("sub_wake_edge", bus.is_empty_to_alu, 1);
    step();
    check("sub_empty", bus.is_empty_to_alu, 0);
    check("sub_op", bus.op_to_alu, OP_SUB);
    check("sub_v1", bus.v1_to_alu, 32'h10);
    check("sub_v2", bus.v2_to_alu, 3);
    check("sub_tag", bus.tag_to_alu, 1);

    // issue bypass: q2 tag 5 broadcast on cdb1 in the issue cycle
    issue(OP_OR, 4'd6, 1'b0, 4'd0, 32'd1, 1'b1, 4'd5, 32'd0);
    bus.cdb1_valid = 1'b1;
    bus.cdb1_tag   = 4'd5;
    bus.cdb1_data  = 32'hAB;
    step();
    clear_in();
    step();
    check("byp_empty", bus.is_empty_to_alu, 0);
    check("byp_v2", bus.v2_to_alu, 32'hAB);
    check("byp_v1", bus.v1_to_alu, 1);
    check("byp_tag", bus.tag_to_alu, 6);

    // both cdbs carry the awaited tag: cdb0 data must win
    issue(OP_AND, 4'd8, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0);
    step();
    clear_in();
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd7;
    bus.cdb0_data  = 32'h111;
    bus.cdb1_valid = 1'b1;
    bus.cdb1_tag   = 4'd7;
    bus.cdb1_data  = 32'h222;
    step();
    clear_in();
    step();
    check("prio_v1", bus.v1_to_alu, 32'h111);
    check("prio_tag", bus.tag_to_alu, 8);

    // fill all 8 entries; entry i is tag i waiting on tag i+8
    for (int i = 0; i < 8; i++) begin
      issue(OP_XOR, i[3:0], 1'b1, i[3:0] + 4'd8, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
    end
    clear_in();
    check("fill_full", bus.full, 1);
    issue(OP_ADD, 4'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd9);
    step();
    clear_in();
    check("ninth_full", bus.full, 1);
    check("ninth_empty", bus.is_empty_to_alu, 1);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd12;
    bus.cdb0_data  = 32'h44;
    step();
    clear_in();
    check("e4_wake_empty", bus.is_empty_to_alu, 1);
    step();
    check("e4_empty", bus.is_empty_to_alu, 0);
    check("e4_tag", bus.tag_to_alu, 4);
    check("e4_v1", bus.v1_to_alu, 32'h44);
    check("e4_not_full", bus.full, 0);
    issue(OP_SLL, 4'd13, 1'b0, 4'd0, 32'h13, 1'b0, 4'd0, 32'd2);
    step();
    clear_in();
    check("refill_full", bus.full, 1);
    check("refill_slot", dut.busy, 8'hFF);
    step();
    check("refill_empty", bus.is_empty_to_alu, 0);
    check("refill_tag", bus.tag_to_alu, 13);
    check("refill_v1", bus.v1_to_alu, 32'h13);
    check("refill_not_full", bus.full, 0);

    // flush leftovers, then rollback the cycle before three ready dispatches
    bus.rollback = 1'b1;
    step();
    clear_in();
    check("flush_full", bus.full, 0);
    check("flush_busy", dut.busy, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      issue(OP_ADD, i[3:0], 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd1);
      step();
    end
    clear_in();
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd10;
    bus.cdb0_data  = 32'h77;
    step();
    clear_in();
    bus.rollback = 1'b1;
    issue(OP_ADD, 4'd11, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    step();
    clear_in();
    check("rb_empty", bus.is_empty_to_alu, 1);
    check("rb_full", bus.full, 0);
    check("rb_hold_tag", bus.tag_to_alu, 13);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rb_no_dispatch", bus.is_empty_to_alu, 1);
    end

    // async reset while an entry is pending and an output is live
    issue(OP_SUB, 4'd14, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0);
    step();
    issue(OP_ADD, 4'd5, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    step();
    clear_in();
    step();
    check("pre_rst_empty", bus.is_empty_to_alu, 0);
    check("pre_rst_tag", bus.tag_to_alu, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", bus.is_empty_to_alu, 1);
    check("arst_tag", bus.tag_to_alu, 0);
    check("arst_v1", bus.v1_to_alu, 0);
    check("arst_op", bus.op_to_alu, 0);
    check("arst_full", bus.full, 0);
    @(negedge clk) rst = 1'b0;
    issue(OP_OR, 4'd2, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd4);
    step();
    clear_in();
    check("post_rst_slot", dut.busy, 8'h01);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd3;
    bus.cdb0_data  = 32'h33;
    step();
    clear_in();
    step();
    check("old_entry_gone", bus.is_empty_to_alu, 1);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = 4'd6;
    bus.cdb0_data  = 32'h66;
    step();
    clear_in();
    step();
    check("post_rst_empty", bus.is_empty_to_alu, 0);
    check("post_rst_tag", bus.tag_to_alu, 2);
    check("post_rst_v1", bus.v1_to_alu, 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
